// File: rtl/fetch_mem_ctrl.sv
// Instruction sequencer: fetch, decode, LDR/STR memory phases and HALT.
// ALU/MOV execution is delegated to the execute controller via start/done.
module fetch_mem_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_rdy,
  input  logic       dp_done,
  output logic [1:0] mem_cmd,
  output logic       addr_sel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       dp_start,
  output logic [1:0] dp_mode,
  output logic       wb_mem,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_UPC,
    S_DEC, S_EXGO, S_EXWT, S_AGO,
    S_AWT, S_LDA, S_RD, S_WB,
    S_SGO, S_SWT, S_WR, S_HALT
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] M_EXEC    = 2'b00;
  localparam logic [1:0] M_ADDR    = 2'b01;
  localparam logic [1:0] M_SDATA   = 2'b10;

  // tmo holds cycles already spent in the state, so the
  // MEM_TIMEOUT-th wait cycle is the last one allowed
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q;
  logic             fault_q;
  logic             set_fault;
  logic             tmo_hit;
  logic             mem_st;
  logic             is_exec, is_mem, is_halt;

  assign tmo_hit = (tmo_q == TMO_LAST);
  assign mem_st  = (state_q == S_IF1) ||
                   (state_q == S_RD)  ||
                   (state_q == S_WR);
  assign is_exec = (opcode == 3'b110) ||
                   (opcode == 3'b101);
  assign is_mem  = ((opcode == 3'b011) ||
                    (opcode == 3'b100)) &&
                   (op == 2'b00);
  assign is_halt = (opcode == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        tmo_q <= '0;
      else if (mem_st)
        tmo_q <= tmo_q + TMO_W'(1);
      if (set_fault)
        fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_fault = 1'b0;
    unique case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1: begin
        if (mem_rdy) begin
          state_d = S_IF2;
        end else if (tmo_hit) begin
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end
      S_IF2:  state_d = S_UPC;
      S_UPC:  state_d = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          is_exec: state_d = S_EXGO;
          is_mem:  state_d = S_AGO;
          is_halt: state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            set_fault = 1'b1;
          end
        endcase
      end
      S_EXGO: state_d = S_EXWT;
      S_EXWT: if (dp_done) state_d = S_IF1;
      S_AGO:  state_d = S_AWT;
      S_AWT:  if (dp_done) state_d = S_LDA;
      S_LDA: begin
        if (opcode == 3'b011) begin
          state_d = S_RD;
        end else if (opcode == 3'b100) begin
          state_d = S_SGO;
        end else begin
          // IR changed under us; treat as illegal
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end
      S_RD: begin
        if (mem_rdy) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end
      S_WB:   state_d = S_IF1;
      S_SGO:  state_d = S_SWT;
      S_SWT:  if (dp_done) state_d = S_WR;
      S_WR: begin
        if (mem_rdy) begin
          state_d = S_IF1;
        end else if (tmo_hit) begin
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    mem_cmd   = CMD_NONE;
    addr_sel  = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    dp_start  = 1'b0;
    dp_mode   = M_EXEC;
    wb_mem    = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        mem_cmd  = CMD_READ;
        addr_sel = 1'b1;
      end
      S_IF2: begin
        mem_cmd  = CMD_READ;
        addr_sel = 1'b1;
        load_ir  = 1'b1;
      end
      S_UPC:  load_pc = 1'b1;
      S_EXGO: dp_start = 1'b1;
      S_AGO: begin
        dp_start = 1'b1;
        dp_mode  = M_ADDR;
      end
      S_AWT:  dp_mode = M_ADDR;
      S_LDA:  load_addr = 1'b1;
      S_RD:   mem_cmd = CMD_READ;
      S_WB:   wb_mem = 1'b1;
      S_SGO: begin
        dp_start = 1'b1;
        dp_mode  = M_SDATA;
      end
      S_SWT:  dp_mode = M_SDATA;
      S_WR:   mem_cmd = CMD_WRITE;
      S_HALT: halted = 1'b1;
      default: begin
        mem_cmd = CMD_NONE;
      end
    endcase
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Bench for fetch_mem_ctrl: per-instruction cycle plans built from
// the sequencing rules, driven and compared cycle by cycle.
module tb_fetch_mem_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_rdy, dp_done;
  logic [1:0] mem_cmd, dp_mode;
  logic       addr_sel, load_ir, load_pc, reset_pc;
  logic       load_addr, dp_start, wb_mem, halted, fault;
  logic [13:0] act;

  always #5 clk = ~clk;

  fetch_mem_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .opcode(opcode), .op(op),
    .mem_rdy(mem_rdy), .dp_done(dp_done),
    .mem_cmd(mem_cmd), .addr_sel(addr_sel),
    .load_ir(load_ir), .load_pc(load_pc),
    .reset_pc(reset_pc), .load_addr(load_addr),
    .dp_start(dp_start), .dp_mode(dp_mode),
    .wb_mem(wb_mem), .halted(halted), .fault(fault)
  );

  assign act = {mem_cmd, addr_sel, load_ir, load_pc,
                reset_pc, load_addr, dp_start, dp_mode,
                wb_mem, halted, fault};

  typedef enum int {
    P_RST, P_IF1, P_IF2, P_UPC, P_DEC, P_EXGO,
    P_EXWT, P_AGO, P_AWT, P_LDA, P_RD, P_WB,
    P_SGO, P_SWT, P_WR, P_HALT
  } ph_t;

  typedef struct {
    ph_t        ph;
    logic       mrdy;
    logic       dpd;
    logic [2:0] oc;
    logic [1:0] op;
    logic       flt;
  } cyc_t;

  cyc_t       q[$];
  logic [2:0] ir_oc = 3'b000;
  logic [1:0] ir_op = 2'b00;
  int         nvec = 0;
  int         nbad = 0;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  // Output vector required in each phase of an instruction
  function automatic logic [13:0] want(ph_t p, logic flt);
    logic [1:0] mc = 2'b00;
    logic [1:0] md = 2'b00;
    logic as = 0, li = 0, lp = 0, rp = 0;
    logic la = 0, ds = 0, wb = 0, h = 0;
    case (p)
      P_RST:  begin rp = 1; lp = 1; end
      P_IF1:  begin mc = 2'b01; as = 1; end
      P_IF2:  begin mc = 2'b01; as = 1; li = 1; end
      P_UPC:  lp = 1;
      P_EXGO: ds = 1;
      P_AGO:  begin ds = 1; md = 2'b01; end
      P_AWT:  md = 2'b01;
      P_LDA:  la = 1;
      P_RD:   mc = 2'b01;
      P_WB:   wb = 1;
      P_SGO:  begin ds = 1; md = 2'b10; end
      P_SWT:  md = 2'b10;
      P_WR:   mc = 2'b10;
      P_HALT: h = 1;
      default: ;
    endcase
    return {mc, as, li, lp, rp, la, ds, md, wb, h, flt};
  endfunction

  task automatic check(input string nm,
                       input logic [13:0] a,
                       input logic [13:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %b want %b (t=%0t)",
               nm, a, e, $time);
    end
  endtask

  task automatic check_int(input string nm,
                           input int a, input int e);
    nvec++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic push(input ph_t p, input logic mr,
                      input logic dd, input logic flt);
    cyc_t c;
    c.ph = p; c.mrdy = mr; c.dpd = dd;
    c.oc = ir_oc; c.op = ir_op; c.flt = flt;
    q.push_back(c);
  endtask

  function automatic int count_ph(ph_t p);
    int n = 0;
    foreach (q[i]) if (q[i].ph == p) n++;
    return n;
  endfunction

  function automatic int first_ph(ph_t p);
    foreach (q[i]) if (q[i].ph == p) return i;
    return -1;
  endfunction

  task automatic halt_cycles(input int hc, input logic flt);
    repeat (hc) push(P_HALT, rb(), rb(), flt);
  endtask

  // w wait cycles with mem_rdy low, then ready; w >= TMO times out
  task automatic mem_wait(input ph_t p, input int w,
                          input int hc, output bit halts);
    halts = (w >= TMO);
    if (halts) begin
      repeat (TMO) push(p, 1'b0, rb(), 1'b0);
      halt_cycles(hc, 1'b1);
    end else begin
      for (int i = 0; i <= w; i++)
        push(p, i == w, rb(), 1'b0);
    end
  endtask

  task automatic wait_dp(input ph_t p, input int lat);
    for (int j = 0; j < lat; j++)
      push(p, rb(), j == lat - 1, 1'b0);
  endtask

  task automatic plan(input logic [2:0] oc, input logic [1:0] opv,
                      input int fw, input int lat, input int mw,
                      input int hc, output bit halts);
    halts = 1'b0;
    mem_wait(P_IF1, fw, hc, halts);
    if (halts) return;
    ir_oc = oc;
    ir_op = opv;
    push(P_IF2, rb(), rb(), 1'b0);
    push(P_UPC, rb(), rb(), 1'b0);
    push(P_DEC, rb(), rb(), 1'b0);
    if (oc == 3'b110 || oc == 3'b101) begin
      push(P_EXGO, rb(), rb(), 1'b0);
      wait_dp(P_EXWT, lat);
    end else if ((oc == 3'b011 || oc == 3'b100) && opv == 2'b00) begin
      push(P_AGO, rb(), rb(), 1'b0);
      wait_dp(P_AWT, lat);
      push(P_LDA, rb(), rb(), 1'b0);
      if (oc == 3'b011) begin
        mem_wait(P_RD, mw, hc, halts);
        if (!halts) push(P_WB, rb(), rb(), 1'b0);
      end else begin
        push(P_SGO, rb(), rb(), 1'b0);
        wait_dp(P_SWT, lat);
        mem_wait(P_WR, mw, hc, halts);
      end
    end else begin
      halts = 1'b1;
      halt_cycles(hc, oc != 3'b111);
    end
  endtask

  // Entered and left at posedge+1
  task automatic run(input int n);
    int k = 0;
    while (q.size() > 0 && k < n) begin
      cyc_t e;
      e = q.pop_front();
      mem_rdy = e.mrdy;
      dp_done = e.dpd;
      opcode  = e.oc;
      op      = e.op;
      @(negedge clk);
      check(e.ph.name(), act, want(e.ph, e.flt));
      @(posedge clk);
      #1;
      k++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("async_rst", act, want(P_RST, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(P_RST, rb(), rb(), 1'b0);
  endtask

  initial begin
    bit h;
    reset_n = 1'b0;
    opcode  = 3'b000;
    op      = 2'b00;
    mem_rdy = 1'b0;
    dp_done = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // MOV, dp_done three cycles after dp_start
    plan(3'b110, 2'b10, 0, 3, 0, 0, h);
    check_int("mov_len", q.size(), 9);
    check_int("fetch_lat", first_ph(P_EXGO), 5);
    check_int("mov_start", count_ph(P_EXGO), 1);
    run(1000);

    // LDR with four wait states in RD
    plan(3'b011, 2'b00, 0, 2, 4, 0, h);
    check_int("ldr_len", q.size(), 14);
    check_int("ldr_rd", count_ph(P_RD), 5);
    check_int("ldr_wb", count_ph(P_WB), 1);
    run(1000);

    // STR with fetch and write wait states
    plan(3'b100, 2'b00, 2, 1, 3, 0, h);
    run(1000);

    // HALT holds for 20 cycles without fault
    plan(3'b111, 2'b01, 0, 1, 0, 20, h);
    check_int("halt_flag", int'(h), 1);
    run(1000);
    do_reset();

    // illegal opcode
    plan(3'b001, 2'b00, 0, 1, 0, 5, h);
    run(1000);
    do_reset();

    // LDR with nonzero op is illegal
    plan(3'b011, 2'b10, 1, 1, 0, 4, h);
    run(1000);
    do_reset();

    // ready on the last allowed fetch wait cycle wins
    plan(3'b101, 2'b01, TMO - 1, 1, 0, 0, h);
    run(1000);

    // fetch timeout
    plan(3'b110, 2'b00, TMO, 1, 0, 5, h);
    check_int("tmo_len", q.size(), TMO + 5);
    run(1000);
    do_reset();

    // RD timeout
    plan(3'b011, 2'b00, 0, 1, 20, 4, h);
    run(1000);
    do_reset();

    // WR timeout
    plan(3'b100, 2'b00, 0, 2, TMO, 4, h);
    run(1000);
    do_reset();

    // reset pulsed while waiting in RD
    plan(3'b011, 2'b00, 0, 1, 10, 0, h);
    run(11);
    do_reset();
    plan(3'b110, 2'b00, 0, 2, 0, 0, h);
    run(1000);

    // random instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [2:0] oc;
      logic [1:0] opv;
      int fw, mw;
      oc  = 3'($urandom_range(7, 0));
      opv = rb() ? 2'b00 : 2'($urandom_range(3, 0));
      fw  = ($urandom_range(19, 0) == 0) ? TMO : $urandom_range(3, 0);
      mw  = ($urandom_range(9, 0) == 0) ? TMO : $urandom_range(4, 0);
      plan(oc, opv, fw, $urandom_range(4, 1), mw, 3, h);
      run(1000);
      if (h) do_reset();
    end
    run(1000);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
